dcache_controller: RTL and testbench
====================================

// Module: dcache_controller
// PURPOSE
//  MEM-stage consumer of the EX/MEM pipeline register. Accepts load/store requests
//  (address, write data, MemRead/MemWrite) and serves them from a direct-mapped,
//  write-back, write-allocate L1 data cache. On a miss it drives a line-wide
//  req/ack transaction to off-chip data memory. While a request is unresolved it
//  asserts cpu_stall_o, which freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
// PARAMETERS
//  NUM_LINES  16   cache lines; power of 2; INDEX_W = log2(NUM_LINES)
//  LINE_W     256  line width in bits (8 words); OFFSET_W = 5
//  ADDR_W     32   byte-address width; TAG_W = ADDR_W - INDEX_W - OFFSET_W (23 at default)
// PORTS
//  clk_i          in   1       clock
//  rst_i          in   1       async active-high reset
//  cpu_addr_i     in   32      byte address from EX/MEM ALU result
//  cpu_data_i     in   32      store data from EX/MEM
//  cpu_MemRead_i  in   1       load request
//  cpu_MemWrite_i in   1       store request
//  cpu_data_o     out  32      load data to MEM/WB
//  cpu_stall_o    out  1       pipeline stall
//  mem_addr_o     out  32      line address to memory; bits [4:0] = 0
//  mem_data_o     out  LINE_W  victim line for write-back
//  mem_enable_o   out  1       memory request valid
//  mem_write_o    out  1       1 = write-back, 0 = line fetch
//  mem_data_i     in   LINE_W  fetched line
//  mem_ack_i      in   1       one-cycle completion pulse from memory
// BEHAVIOUR
//  - Address split: tag = addr[31:9], index = addr[8:5], word = addr[4:2]. Word k of a
//    line is bits [32k+31:32k]. addr[1:0] is ignored; accesses are word-only.
//  - req = cpu_MemRead_i | cpu_MemWrite_i. If both are set, the write wins.
//  - hit = valid[index] & (tag_array[index] == tag).
//  - States: IDLE, WRITEBACK, ALLOCATE, REFILL_DONE.
//  - IDLE, req & hit:
//      cpu_data_o = selected word, combinational in the same cycle; cpu_stall_o = 0.
//      A write updates the word and sets dirty at the clock edge. Zero added latency.
//  - IDLE, req & miss: cpu_stall_o = 1 combinationally.
//      Next state is WRITEBACK if valid & dirty, otherwise ALLOCATE.
//  - WRITEBACK: mem_enable_o = 1, mem_write_o = 1, mem_addr_o = {old_tag, index, 5'b0},
//    mem_data_o = victim line. On mem_ack_i go to ALLOCATE.
//  - ALLOCATE: mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {tag, index, 5'b0}.
//    On mem_ack_i: line <= mem_data_i, valid <= 1, dirty <= 0, tag <= tag;
//    next state is REFILL_DONE.
//  - REFILL_DONE: cpu_stall_o = 1, mem_enable_o = 0; go to IDLE.
//    The request, still held by the stalled EX/MEM, then hits in IDLE.
//  - cpu_stall_o = 1 in every state other than IDLE.
//  - mem_enable_o and the request fields stay stable until mem_ack_i. Memory latency is
//    unbounded. The cycle after ack deasserts enable or starts the next transaction.
//  - mem_ack_i is ignored in IDLE and REFILL_DONE.
//  - Miss latency with memory latency L: clean miss = L + 2 stall cycles;
//    dirty miss = 2L + 2 stall cycles.
//  - Reset (async, any state): state = IDLE; all valid/dirty = 0.
//    cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o, cpu_data_o = 0.
//    An in-flight memory transaction is abandoned; a late ack is ignored.
//    Tag and data arrays are not reset.
//  - The CPU request inputs are assumed stable while cpu_stall_o = 1, because the
//    EX/MEM register holds them.
// STRUCTURE
//  - cache_pkg:
//      typedef enum {IDLE, WRITEBACK, ALLOCATE, REFILL_DONE} cache_state_t;
//      localparams OFFSET_W, INDEX_W, TAG_W, WORDS_PER_LINE.
//  - Sub-module dcache_sram holds the tag/valid/dirty/data arrays, with one combinational
//    read port and one synchronous write port. Its valid/dirty bits clear on rst_i.
//  - dcache_controller contains the FSM, hit logic, word merge and output mux.
// TESTING
//  1. Reset, then read 0x0000_0040, memory ack after 5 cycles returning word k = k+1
//     -> mem_addr_o = 0x40, mem_write_o = 0, stall for 7 cycles, then cpu_data_o = 0x1.
//  2. Write 0xDEADBEEF to 0x44 (hit)
//     -> no stall; a following read of 0x44 returns 0xDEADBEEF with no stall.
//  3. Read 0x0000_0240 (same index 2, tag 1)
//     -> write-back to 0x40 whose line word1 = 0xDEADBEEF, then fetch from 0x240;
//        stall = 2L + 2.
//  4. Read 0x0000_0060 (clean miss, index 3)
//     -> no write-back, a single fetch; a stray ack in IDLE has no effect.
//  5. Assert rst_i during ALLOCATE
//     -> mem_enable_o and cpu_stall_o drop at once; a later read of 0x240 misses again.
//  6. Read and write asserted together on a hit to 0x48 with 0x5
//     -> the write takes effect; a read of 0x48 returns 0x5.

Source files
------------

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and geometry for the L1 data cache
package cache_pkg;

  localparam int ADDR_W         = 32;
  localparam int NUM_LINES      = 16;
  localparam int LINE_W         = 256;
  localparam int OFFSET_W       = 5;
  localparam int INDEX_W        = $clog2(NUM_LINES);
  localparam int TAG_W          = ADDR_W - INDEX_W - OFFSET_W;
  localparam int WORDS_PER_LINE = LINE_W / 32;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WRITEBACK   = 2'd1,
    ALLOCATE    = 2'd2,
    REFILL_DONE = 2'd3
  } cache_state_t;

endpackage

// File: rtl/dcache_sram.sv
// rtl/dcache_sram.sv - tag/valid/dirty/data arrays, combinational read, synchronous write
module dcache_sram #(
  parameter int NUM_LINES = 16,
  parameter int LINE_W    = 256,
  parameter int INDEX_W   = 4,
  parameter int TAG_W     = 23
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [INDEX_W-1:0] rd_index_i,
  output logic               rd_valid_o,
  output logic               rd_dirty_o,
  output logic [TAG_W-1:0]   rd_tag_o,
  output logic [LINE_W-1:0]  rd_line_o,
  input  logic               wr_en_i,
  input  logic [INDEX_W-1:0] wr_index_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  logic [LINE_W-1:0]  wr_line_i,
  input  logic               wr_dirty_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_index_i] <= 1'b1;
      dirty_q[wr_index_i] <= wr_dirty_i;
    end
  end

  // Tag and data storage is deliberately left unreset; valid gates its use.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_line_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_dirty_o = dirty_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_line_o  = data_q[rd_index_i];

endmodule

// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - direct-mapped write-back write-allocate L1 D-cache controller
module dcache_controller
  import cache_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int LINE_W    = 256,
  parameter int ADDR_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  input  logic              cpu_MemRead_i,
  input  logic              cpu_MemWrite_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TG_W  = ADDR_W - IDX_W - OFFSET_W;
  localparam int WPL   = LINE_W / 32;
  localparam int WSEL_W = $clog2(WPL);

  cache_state_t state_q, state_d;

  logic [TG_W-1:0]   req_tag;
  logic [IDX_W-1:0]  req_index;
  logic [WSEL_W-1:0] req_word;
  logic              req, hit;

  logic              rd_valid, rd_dirty;
  logic [TG_W-1:0]   rd_tag;
  logic [LINE_W-1:0] rd_line;
  logic [WPL-1:0][31:0] rd_words, merged_words;

  logic              wr_en, wr_dirty;
  logic [LINE_W-1:0] wr_line;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^cpu_addr_i[1:0];

  assign req_tag   = cpu_addr_i[ADDR_W-1 -: TG_W];
  assign req_index = cpu_addr_i[OFFSET_W +: IDX_W];
  assign req_word  = cpu_addr_i[OFFSET_W-1:2];
  assign req       = cpu_MemRead_i | cpu_MemWrite_i;
  assign hit       = rd_valid & (rd_tag == req_tag);

  assign rd_words = rd_line;

  always_comb begin
    merged_words           = rd_words;
    merged_words[req_word] = cpu_data_i;
  end

  dcache_sram #(
    .NUM_LINES (NUM_LINES),
    .LINE_W    (LINE_W),
    .INDEX_W   (IDX_W),
    .TAG_W     (TG_W)
  ) u_sram (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd_index_i (req_index),
    .rd_valid_o (rd_valid),
    .rd_dirty_o (rd_dirty),
    .rd_tag_o   (rd_tag),
    .rd_line_o  (rd_line),
    .wr_en_i    (wr_en),
    .wr_index_i (req_index),
    .wr_tag_i   (req_tag),
    .wr_line_i  (wr_line),
    .wr_dirty_i (wr_dirty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    cpu_data_o   = '0;
    cpu_stall_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    wr_en        = 1'b0;
    wr_dirty     = 1'b1;
    wr_line      = merged_words;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            cpu_data_o = rd_words[req_word];
            wr_en      = cpu_MemWrite_i;
          end else begin
            cpu_stall_o = 1'b1;
            state_d     = (rd_valid & rd_dirty) ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        cpu_stall_o  = 1'b1;
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {rd_tag, req_index, {OFFSET_W{1'b0}}};
        mem_data_o   = rd_line;
        if (mem_ack_i) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        cpu_stall_o  = 1'b1;
        mem_enable_o = 1'b1;
        mem_addr_o   = {req_tag, req_index, {OFFSET_W{1'b0}}};
        if (mem_ack_i) begin
          wr_en    = 1'b1;
          wr_dirty = 1'b0;
          wr_line  = mem_data_i;
          state_d  = REFILL_DONE;
        end
      end
      REFILL_DONE: begin
        cpu_stall_o = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset also silences the request-driven outputs while the CPU still holds a request.
    if (rst_i) begin
      cpu_data_o   = '0;
      cpu_stall_o  = 1'b0;
      mem_addr_o   = '0;
      mem_data_o   = '0;
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
      wr_en        = 1'b0;
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// tb/tb_dcache_controller.sv - self-checking bench with a transaction-level cache model
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [31:0]  cpu_addr_i = '0;
  logic [31:0]  cpu_data_i = '0;
  logic         cpu_MemRead_i = 1'b0;
  logic         cpu_MemWrite_i = 1'b0;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack_i = 1'b0;

  dcache_controller dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cpu_addr_i     (cpu_addr_i),
    .cpu_data_i     (cpu_data_i),
    .cpu_MemRead_i  (cpu_MemRead_i),
    .cpu_MemWrite_i (cpu_MemWrite_i),
    .cpu_data_o     (cpu_data_o),
    .cpu_stall_o    (cpu_stall_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_enable_o   (mem_enable_o),
    .mem_write_o    (mem_write_o),
    .mem_data_i     (mem_data_i),
    .mem_ack_i      (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Off-chip memory: written lines are stored, untouched lines follow a fixed pattern.
  logic [255:0] mem_store [logic [31:0]];

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    logic [255:0] l;
    if (mem_store.exists(a)) return mem_store[a];
    for (int k = 0; k < 8; k++) l[32*k +: 32] = (((a >> 5) - 32'd2) << 8) | 32'(k + 1);
    return l;
  endfunction

  int  lat = 3;
  bit  stray_ack = 1'b0;
  int  en_cnt = 0;

  always @(posedge clk_i) begin
    #1;
    mem_ack_i = 1'b0;
    if (rst_i || !mem_enable_o) begin
      en_cnt = 0;
      if (stray_ack) begin
        mem_ack_i  = 1'b1;
        mem_data_i = {8{32'hBAD0BAD0}};
        stray_ack  = 1'b0;
      end
    end else begin
      en_cnt++;
      if (en_cnt >= lat) begin
        mem_ack_i  = 1'b1;
        mem_data_i = mem_line(mem_addr_o);
        en_cnt     = 0;
      end
    end
  end

  // Reference model: cache contents plus a queue of outstanding line transfers.
  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } op_t;

  bit          m_valid [16];
  bit          m_dirty [16];
  logic [22:0] m_tag   [16];
  logic [31:0] m_data  [16][8];
  op_t         ops[$];
  bit          refill_pend = 1'b0;

  logic [31:0]  e_cdata, e_addr;
  logic [255:0] e_mdata, ln;
  logic         e_stall, e_en, e_wr, m_hit;
  int           idx, wd;
  op_t          op;

  always @(negedge clk_i) begin
    if (rst_i) begin
      chk("rst_stall", cpu_stall_o, 0);
      chk("rst_cdata", cpu_data_o, 0);
      chk("rst_en", mem_enable_o, 0);
      chk("rst_wr", mem_write_o, 0);
      chk("rst_addr", mem_addr_o, 0);
      chk("rst_mdata", mem_data_o, 0);
      ops.delete();
      refill_pend = 1'b0;
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 1'b0;
        m_dirty[i] = 1'b0;
      end
    end else begin
      idx = int'(cpu_addr_i[8:5]);
      wd  = int'(cpu_addr_i[4:2]);
      m_hit = m_valid[idx] && (m_tag[idx] == cpu_addr_i[31:9]);
      e_stall = 0; e_en = 0; e_wr = 0; e_addr = '0; e_mdata = '0; e_cdata = '0;
      if (ops.size() != 0) begin
        e_stall = 1; e_en = 1; e_wr = ops[0].wr; e_addr = ops[0].addr;
        e_mdata = ops[0].wr ? ops[0].data : '0;
      end else if (refill_pend) begin
        e_stall = 1;
      end else if (cpu_MemRead_i || cpu_MemWrite_i) begin
        if (m_hit) e_cdata = m_data[idx][wd];
        else       e_stall = 1;
      end
      chk("cpu_stall", cpu_stall_o, e_stall);
      chk("cpu_data", cpu_data_o, e_cdata);
      chk("mem_enable", mem_enable_o, e_en);
      chk("mem_write", mem_write_o, e_wr);
      chk("mem_addr", mem_addr_o, e_addr);
      chk("mem_data", mem_data_o, e_mdata);

      if (ops.size() != 0) begin
        if (mem_ack_i) begin
          op = ops.pop_front();
          if (op.wr) begin
            mem_store[op.addr] = op.data;
          end else begin
            ln = mem_line(op.addr);
            for (int k = 0; k < 8; k++) m_data[idx][k] = ln[32*k +: 32];
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = op.addr[31:9];
            refill_pend  = 1'b1;
          end
        end
      end else if (refill_pend) begin
        refill_pend = 1'b0;
      end else if (cpu_MemRead_i || cpu_MemWrite_i) begin
        if (m_hit) begin
          if (cpu_MemWrite_i) begin
            m_data[idx][wd] = cpu_data_i;
            m_dirty[idx]    = 1'b1;
          end
        end else begin
          if (m_valid[idx] && m_dirty[idx]) begin
            op.wr = 1'b1;
            op.addr = {m_tag[idx], 4'(idx), 5'b0};
            for (int k = 0; k < 8; k++) op.data[32*k +: 32] = m_data[idx][k];
            ops.push_back(op);
          end
          op.wr = 1'b0;
          op.addr = {cpu_addr_i[31:5], 5'b0};
          op.data = '0;
          ops.push_back(op);
        end
      end
    end
  end

  int           st;
  logic [31:0]  rd, wb_addr, f_addr;
  logic [255:0] wb_data;
  bit           wb_seen, f_seen;

  task automatic access(input logic [31:0] a, input logic [31:0] d, input bit r, input bit w);
    bit done;
    @(posedge clk_i); #1;
    cpu_addr_i = a; cpu_data_i = d; cpu_MemRead_i = r; cpu_MemWrite_i = w;
    st = 0; wb_seen = 0; f_seen = 0; done = 0;
    wb_addr = '0; f_addr = '0; wb_data = '0; rd = '0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk_i);
      if (mem_enable_o && mem_write_o && !wb_seen) begin
        wb_seen = 1; wb_addr = mem_addr_o; wb_data = mem_data_o;
      end
      if (mem_enable_o && !mem_write_o && !f_seen) begin
        f_seen = 1; f_addr = mem_addr_o;
      end
      if (!cpu_stall_o) begin
        rd = cpu_data_o;
        done = 1;
      end else begin
        st++;
      end
    end
    if (!done) chk("access_timeout", 0, 1);
  endtask

  task automatic idle_cycle();
    @(posedge clk_i); #1;
    cpu_MemRead_i = 0; cpu_MemWrite_i = 0;
    @(negedge clk_i);
  endtask

  initial begin
    int tg, ix, wsel;
    bit r, w;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    lat = 5;
    access(32'h40, 0, 1, 0);
    chk("t1_stall_cycles", st, 7);
    chk("t1_fetch_addr", f_addr, 32'h40);
    chk("t1_no_wb", wb_seen, 0);
    chk("t1_rdata", rd, 32'h1);

    access(32'h44, 32'hDEADBEEF, 0, 1);
    chk("t2_wr_stall", st, 0);
    access(32'h44, 0, 1, 0);
    chk("t2_rd_stall", st, 0);
    chk("t2_rdata", rd, 32'hDEADBEEF);

    lat = 4;
    access(32'h240, 0, 1, 0);
    chk("t3_wb_addr", wb_addr, 32'h40);
    chk("t3_wb_word1", wb_data[63:32], 32'hDEADBEEF);
    chk("t3_fetch_addr", f_addr, 32'h240);
    chk("t3_stall_cycles", st, 10);
    chk("t3_rdata", rd, 32'h1001);

    lat = 2;
    stray_ack = 1'b1;
    idle_cycle();
    idle_cycle();
    access(32'h60, 0, 1, 0);
    chk("t4_no_wb", wb_seen, 0);
    chk("t4_fetch_addr", f_addr, 32'h60);
    chk("t4_stall_cycles", st, 4);
    chk("t4_rdata", rd, 32'h101);

    lat = 30;
    @(posedge clk_i); #1;
    cpu_addr_i = 32'h1000; cpu_MemRead_i = 1; cpu_MemWrite_i = 0;
    begin
      bit seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk_i);
        if (mem_enable_o && !mem_write_o) seen = 1;
      end
      chk("t5_reached_allocate", seen, 1);
    end
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(negedge clk_i);
    chk("t5_enable_drop", mem_enable_o, 0);
    chk("t5_stall_drop", cpu_stall_o, 0);
    @(posedge clk_i); #1;
    cpu_MemRead_i = 0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    stray_ack = 1'b1;
    idle_cycle();
    idle_cycle();
    lat = 3;
    access(32'h240, 0, 1, 0);
    chk("t5_remiss_stall", st, 5);
    chk("t5_remiss_fetch", f_addr, 32'h240);

    lat = 2;
    access(32'h48, 0, 1, 0);
    access(32'h48, 32'h5, 1, 1);
    chk("t6_both_stall", st, 0);
    access(32'h48, 0, 1, 0);
    chk("t6_rdata", rd, 32'h5);

    for (int n = 0; n < 400; n++) begin
      tg   = $urandom_range(0, 3);
      ix   = $urandom_range(0, 3);
      wsel = $urandom_range(0, 7);
      lat  = $urandom_range(1, 5);
      case ($urandom_range(0, 2))
        0: begin r = 1; w = 0; end
        1: begin r = 0; w = 1; end
        default: begin r = 1; w = 1; end
      endcase
      if ($urandom_range(0, 7) == 0) stray_ack = 1'b1;
      access((32'(tg) << 9) | (32'(ix) << 5) | (32'(wsel) << 2) | 32'($urandom_range(0, 3)),
             $urandom, r, w);
      if ($urandom_range(0, 5) == 0) idle_cycle();
    end

    idle_cycle();
    idle_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
